mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port if_req  input  1  instruction-fetch request; always a 4-byte read.
REQ-005 Port if_addr  input  ADDR_W  fetch address; byte-addressed.
REQ-006 Port if_flush  input  1  cancels an in-flight or pending fetch (branch taken).
REQ-007 Port if_data  output  32  fetched word, little-endian assembly.
REQ-008 Port if_done  output  1  one-cycle pulse; if_data is valid in this cycle.
REQ-009 Port mem_req  input  1  data-access request from the MEM stage.
REQ-010 Port mem_we  input  1  1 = store, 0 = load.
REQ-011 Port mem_len  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-012 Port mem_addr  input  ADDR_W  data address.
REQ-013 Port mem_wdata  input  32  store data; low bytes used first.
REQ-014 Port mem_rdata  output  32  load data, zero-extended above the length.
REQ-015 Port mem_done  output  1  one-cycle completion pulse for a load or store.
REQ-016 Port stall_req_if  output  1  combinational: if_req & ~if_done & ~if_flush.
REQ-017 Port stall_req_mem  output  1  combinational: mem_req & ~mem_done.
REQ-018 Port ram_a  output  ADDR_W  byte address to the 8-bit RAM.
REQ-019 Port ram_dout  output  8  write byte.
REQ-020 Port ram_wr  output  1  1 = write the byte this cycle.
REQ-021 Port ram_din  input  8  read byte; valid the cycle after its address.

Function
REQ-022 FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
REQ-023 Only in IDLE is a request accepted; on acceptance, the address, length, we and wdata are latched; later input changes are ignored.
REQ-024 Arbitration: when mem_req and if_req are both high in IDLE, MEM wins; IF is accepted only when mem_req is low.
REQ-025 N = bytes for the transfer (1/2/4); byte counter k runs 0..N-1.
REQ-026 Read (IF_RD/MEM_RD): in busy cycle k, ram_a = addr+k and ram_wr = 0.
REQ-027 Read: ram_din is sampled as byte k at the rising edge that ends cycle k+1; the FSM stays busy through cycle N and then enters DONE.
REQ-028 Write (MEM_WR): in cycle k, ram_a = addr+k, ram_dout = wdata[8k+7:8k] and ram_wr = 1; DONE follows cycle N-1.
REQ-029 DONE lasts one cycle; if_done or mem_done is high only in this cycle, with the data outputs valid; the next state is IDLE.
REQ-030 A request that is still high in the DONE cycle is not accepted; the requester deasserts req on seeing done.
REQ-031 Address increment wraps modulo 2^ADDR_W.
REQ-032 if_flush in IDLE blocks IF acceptance that cycle.
REQ-033 if_flush in IF_RD returns the FSM to IDLE at the next edge, with no if_done and if_data unchanged.
REQ-034 if_flush has no effect on MEM transactions.
REQ-035 ram_wr is 0 in every state except MEM_WR.
REQ-036 ram_a and ram_dout hold their last value when IDLE.
REQ-037 Latency: read word = 6 cycles from the acceptance edge to the done cycle inclusive; read byte = 3 cycles; write word = 5 cycles; write byte = 2 cycles.
REQ-038 if_data and mem_rdata hold their value until the next completion of the same type.

Reset
REQ-039 rst low immediately forces IDLE, k = 0, ram_wr = 0, ram_a = 0, ram_dout = 0, if_data = 0, mem_rdata = 0, if_done = 0 and mem_done = 0, independent of clk.
REQ-040 Reset during a write aborts it immediately; bytes already written stay, remaining bytes are not written.
REQ-041 After rst rises, the first acceptance occurs at the first rising edge with a request present.

Verification
REQ-042 IF read of 0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a 0x100..0x103, if_done in cycle 6, if_data = 0x00100513.
REQ-043 Store word 0xDEADBEEF to 0x2000 -> ram_wr high for 4 cycles with bytes EF,BE,AD,DE at 0x2000..0x2003, mem_done in cycle 5.
REQ-044 if_req and mem_req (load byte 0x40 = 0x80) in the same cycle -> MEM served first, mem_rdata = 0x00000080; IF accepted in the first IDLE cycle after DONE.
REQ-045 if_flush in IF_RD cycle 2 -> IDLE next edge, no if_done; a new if_req to 0x200 completes normally.
REQ-046 rst low during MEM_WR cycle 1 -> ram_wr = 0 at once, only byte 0 written, all outputs at reset values.
REQ-047 Load half at address 0xFFFFFFFF -> ram_a = 0xFFFFFFFF then 0x00000000, mem_rdata[31:16] = 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory controller: serialises 4-byte instruction fetches and 1/2/4-byte data
// loads/stores onto a byte-wide synchronous RAM. MEM requests win over IF.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stall_req_if,
    output logic              stall_req_mem,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned K_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [K_W-1:0]      r_k;
    logic [K_W-1:0]      r_n;
    logic                r_src_if;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_buf;
    logic [ADDR_W-1:0]   r_ram_a;
    logic [7:0]          r_ram_dout;
    logic                r_ram_wr;
    logic [DATA_W-1:0]   r_if_data;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_if_done;
    logic                r_mem_done;

    logic [K_W-1:0]      w_req_n;
    logic [K_W-1:0]      w_k_inc;
    logic [1:0]          w_idx;
    logic                w_read_end;
    logic                w_last_byte;
    logic                w_addr_step;
    logic [DATA_W-1:0]   w_rd_word;
    logic [7:0]          w_wr_next_byte;

    assign w_req_n        = (mem_len == 2'b00) ? K_W'(1) :
                            (mem_len == 2'b01) ? K_W'(2) : K_W'(4);
    assign w_k_inc        = r_k + K_W'(1);
    assign w_idx          = 2'(r_k - K_W'(1));
    assign w_read_end     = (r_k == r_n);
    assign w_last_byte    = (r_k == r_n - K_W'(1));
    assign w_addr_step    = (r_k < r_n - K_W'(1));
    assign w_wr_next_byte = r_wdata[{w_k_inc[1:0], 3'b000} +: 8];

    // Byte returned by the RAM this cycle belongs to the previous counter value
    always_comb begin
        w_rd_word = r_buf;
        if (r_k != '0) begin
            w_rd_word[{w_idx, 3'b000} +: 8] = ram_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_next = mem_we ? MEM_WR : MEM_RD;
                end else if (if_req && !if_flush) begin
                    w_next = IF_RD;
                end
            end
            IF_RD: begin
                if (if_flush) begin
                    w_next = IDLE;
                end else if (w_read_end) begin
                    w_next = DONE;
                end
            end
            MEM_RD: begin
                if (w_read_end) begin
                    w_next = DONE;
                end
            end
            MEM_WR: begin
                if (w_last_byte) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Transfer datapath: request latch, address/byte sequencing, read assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k         <= '0;
            r_n         <= '0;
            r_src_if    <= 1'b0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_ram_a     <= '0;
            r_ram_dout  <= '0;
            r_ram_wr    <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_next != IDLE) begin
                        r_k   <= '0;
                        r_buf <= '0;
                        if (w_next == IF_RD) begin
                            r_n      <= K_W'(4);
                            r_src_if <= 1'b1;
                            r_ram_a  <= if_addr;
                        end else begin
                            r_n      <= w_req_n;
                            r_src_if <= 1'b0;
                            r_ram_a  <= mem_addr;
                            r_wdata  <= mem_wdata;
                            if (mem_we) begin
                                r_ram_dout <= mem_wdata[7:0];
                                r_ram_wr   <= 1'b1;
                            end
                        end
                    end
                end
                IF_RD, MEM_RD: begin
                    r_k   <= w_k_inc;
                    r_buf <= w_rd_word;
                    if (w_addr_step) begin
                        r_ram_a <= r_ram_a + ADDR_W'(1);
                    end
                    if (w_next == DONE) begin
                        if (r_src_if) begin
                            r_if_data <= w_rd_word;
                            r_if_done <= 1'b1;
                        end else begin
                            r_mem_rdata <= w_rd_word;
                            r_mem_done  <= 1'b1;
                        end
                    end
                end
                MEM_WR: begin
                    if (w_last_byte) begin
                        r_ram_wr   <= 1'b0;
                        r_mem_done <= 1'b1;
                    end else begin
                        r_k        <= w_k_inc;
                        r_ram_a    <= r_ram_a + ADDR_W'(1);
                        r_ram_dout <= w_wr_next_byte;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign if_data       = r_if_data;
    assign if_done       = r_if_done;
    assign mem_rdata     = r_mem_rdata;
    assign mem_done      = r_mem_done;
    assign ram_a         = r_ram_a;
    assign ram_dout      = r_ram_dout;
    assign ram_wr        = r_ram_wr;
    assign stall_req_if  = if_req & ~if_done & ~if_flush;
    assign stall_req_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus queues expected completions and RAM
// writes; a monitor pops and compares whenever the DUT signals done or writes.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stall_req_if;
    logic        stall_req_mem;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_data      (if_data),
        .if_done      (if_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_len      (mem_len),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .stall_req_if (stall_req_if),
        .stall_req_mem(stall_req_mem),
        .ram_a        (ram_a),
        .ram_dout     (ram_dout),
        .ram_wr       (ram_wr),
        .ram_din      (ram_din)
    );

    always begin
        clk = 1'b0;
        #5;
        clk = 1'b1;
        #5;
    end

    logic [7:0]  ram [0:16383];
    logic [63:0] exp_if [$];
    logic [63:0] exp_mem [$];
    logic [63:0] exp_wr [$];
    logic [63:0] mon_e;
    logic [31:0] last_load;
    int          cyc;
    int          a;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic put_word(input logic [31:0] addr, input logic [31:0] data);
        for (int i = 0; i < 4; i++) begin
            ram[14'(addr + 32'(i))] = data[8*i +: 8];
        end
    endtask

    task automatic issue_if(input logic [31:0] addr);
        if_req  = 1'b1;
        if_addr = addr;
    endtask

    task automatic issue_mem(input logic we, input logic [1:0] len,
                             input logic [31:0] addr, input logic [31:0] wdata);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_len   = len;
        mem_addr  = addr;
        mem_wdata = wdata;
    endtask

    task automatic wait_done(input bit is_if);
        int n;
        n = 0;
        while (!(is_if ? if_done : mem_done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", is_if ? "if" : "mem");
        end
    endtask

    // Compare every completion and every RAM write against the scoreboard
    task automatic mon_step();
        if (if_done) begin
            if (exp_if.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_done_unexpected actual=%h required=none", if_data);
            end else begin
                mon_e = exp_if.pop_front();
                chk("if_done_cyc_data", {32'(cyc), if_data}, mon_e);
            end
        end
        if (mem_done) begin
            if (exp_mem.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_done_unexpected actual=%h required=none", mem_rdata);
            end else begin
                mon_e = exp_mem.pop_front();
                chk("mem_done_cyc_data", {32'(cyc), mem_rdata}, mon_e);
            end
        end
        if (ram_wr) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ram_wr_unexpected actual=%h/%h required=none", ram_a, ram_dout);
            end else begin
                mon_e = exp_wr.pop_front();
                chk("ram_write", {24'h0, ram_a, ram_dout}, mon_e);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        last_load = '0;
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_len   = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        ram_din   = '0;
        for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
        put_word(32'h100, 32'h0010_0513);
        put_word(32'h200, 32'h0000_4137);
        ram[14'h0040] = 8'h80;
        ram[14'h3001] = 8'h55;
        ram[14'h3FFF] = 8'hAB;
        ram[14'h0000] = 8'hCD;

        fork
            forever begin
                @(posedge clk);
                cyc <= cyc + 1;
                ram_din <= ram[ram_a[13:0]];
                if (ram_wr) ram[ram_a[13:0]] <= ram_dout;
            end
            forever begin
                @(negedge clk);
                mon_step();
            end
            begin
                #200000;
                $display("FAIL watchdog actual=running required=finished");
                $fatal(1);
            end
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ram_a", 64'(ram_a), 64'h0);
        chk("rst_ram_wr", 64'(ram_wr), 64'h0);
        chk("rst_if_data", 64'(if_data), 64'h0);
        chk("rst_mem_rdata", 64'(mem_rdata), 64'h0);
        chk("rst_dones", {62'h0, if_done, mem_done}, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // IF word read of 0x100
        a = cyc + 1;
        issue_if(32'h100);
        exp_if.push_back({32'(a + 5), 32'h0010_0513});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("if_rd_ram_a", 64'(ram_a), 64'(32'h100 + 32'(k)));
            if (k == 0) chk("stall_if_busy", 64'(stall_req_if), 64'h1);
        end
        wait_done(1'b1);
        if_req = 1'b0;
        @(negedge clk);

        // Store word 0xDEADBEEF to 0x2000
        a = cyc + 1;
        issue_mem(1'b1, 2'b10, 32'h2000, 32'hDEAD_BEEF);
        exp_wr.push_back({24'h0, 32'h2000, 8'hEF});
        exp_wr.push_back({24'h0, 32'h2001, 8'hBE});
        exp_wr.push_back({24'h0, 32'h2002, 8'hAD});
        exp_wr.push_back({24'h0, 32'h2003, 8'hDE});
        exp_mem.push_back({32'(a + 4), last_load});
        @(negedge clk);
        chk("stall_mem_busy", 64'(stall_req_mem), 64'h1);
        wait_done(1'b0);
        mem_req = 1'b0;
        @(negedge clk);

        // Load with len 11 (word) from 0x2000
        a = cyc + 1;
        issue_mem(1'b0, 2'b11, 32'h2000, 32'h0);
        last_load = 32'hDEAD_BEEF;
        exp_mem.push_back({32'(a + 5), last_load});
        @(negedge clk);
        wait_done(1'b0);
        mem_req = 1'b0;
        @(negedge clk);

        // Load half from 0x2002
        a = cyc + 1;
        issue_mem(1'b0, 2'b01, 32'h2002, 32'h0);
        last_load = 32'h0000_DEAD;
        exp_mem.push_back({32'(a + 3), last_load});
        @(negedge clk);
        wait_done(1'b0);
        mem_req = 1'b0;
        @(negedge clk);

        // Simultaneous IF and MEM byte load: MEM first, IF after the IDLE cycle
        a = cyc + 1;
        issue_mem(1'b0, 2'b00, 32'h40, 32'h0);
        issue_if(32'h100);
        last_load = 32'h0000_0080;
        exp_mem.push_back({32'(a + 2), last_load});
        exp_if.push_back({32'(a + 9), 32'h0010_0513});
        @(negedge clk);
        wait_done(1'b0);
        mem_req = 1'b0;
        wait_done(1'b1);
        if_req = 1'b0;
        @(negedge clk);

        // Store byte: only wdata[7:0] written
        a = cyc + 1;
        issue_mem(1'b1, 2'b00, 32'h50, 32'h1122_3344);
        exp_wr.push_back({24'h0, 32'h50, 8'h44});
        exp_mem.push_back({32'(a + 1), last_load});
        @(negedge clk);
        wait_done(1'b0);
        mem_req = 1'b0;
        @(negedge clk);

        // Flush during IF_RD cycle 2: no if_done, if_data held
        issue_if(32'h200);
        repeat (3) @(negedge clk);
        if_flush = 1'b1;
        #1;
        chk("stall_if_flush", 64'(stall_req_if), 64'h0);
        if_req = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        chk("flush_if_data_hold", 64'(if_data), 64'h0010_0513);
        repeat (6) @(negedge clk);
        chk("flush_if_data_hold_late", 64'(if_data), 64'h0010_0513);

        // Flush in IDLE delays acceptance by one cycle; then 0x200 completes
        a = cyc + 2;
        issue_if(32'h200);
        if_flush = 1'b1;
        exp_if.push_back({32'(a + 5), 32'h0000_4137});
        @(negedge clk);
        if_flush = 1'b0;
        wait_done(1'b1);
        if_req = 1'b0;
        @(negedge clk);

        // Half load across the address wrap
        a = cyc + 1;
        issue_mem(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0);
        last_load = 32'h0000_CDAB;
        exp_mem.push_back({32'(a + 3), last_load});
        @(negedge clk);
        chk("wrap_ram_a0", 64'(ram_a), 64'hFFFF_FFFF);
        @(negedge clk);
        chk("wrap_ram_a1", 64'(ram_a), 64'h0);
        wait_done(1'b0);
        mem_req = 1'b0;
        @(negedge clk);

        // Reset during MEM_WR cycle 1
        issue_mem(1'b1, 2'b10, 32'h3000, 32'hCAFE_F00D);
        exp_wr.push_back({24'h0, 32'h3000, 8'h0D});
        @(posedge clk);
        @(posedge clk);
        #2;
        rst     = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("abort_ram_wr", 64'(ram_wr), 64'h0);
        chk("abort_ram_a", 64'(ram_a), 64'h0);
        chk("abort_ram_dout", 64'(ram_dout), 64'h0);
        chk("abort_if_data", 64'(if_data), 64'h0);
        chk("abort_mem_rdata", 64'(mem_rdata), 64'h0);
        chk("abort_dones", {62'h0, if_done, mem_done}, 64'h0);
        chk("abort_byte0", 64'(ram[14'h3000]), 64'h0D);
        chk("abort_byte1", 64'(ram[14'h3001]), 64'h55);
        @(negedge clk);

        // First request after reset release is accepted at the next edge
        rst = 1'b1;
        a = cyc + 1;
        issue_mem(1'b0, 2'b10, 32'h3000, 32'h0);
        last_load = 32'h0000_550D;
        exp_mem.push_back({32'(a + 5), last_load});
        @(negedge clk);
        wait_done(1'b0);
        mem_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("if_queue_empty", 64'(exp_if.size()), 64'h0);
        chk("mem_queue_empty", 64'(exp_mem.size()), 64'h0);
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
